alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Upstream issue stage for the combinational `alu` block.
- Buffers operand/opcode triples in a small FIFO and drives them one at a time onto the ALU's `a`/`b`/`op` inputs.
- Captures the ALU's `out` and presents it downstream over a valid/ready handshake, tagged with its opcode.
- Decouples the producer from the single-issue ALU.

Parameters:
- OP_W, 4, opcode width; matches ALU `op`.
- RES_W, 4, result width; matches ALU `out`.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a triple.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  1  operand a.
- in_b  in  1  operand b.
- in_op  in  OP_W  opcode.
- alu_a  out  1  registered drive to ALU `a`.
- alu_b  out  1  registered drive to ALU `b`.
- alu_op  out  OP_W  registered drive to ALU `op`.
- alu_out  in  RES_W  ALU result, combinational from alu_a/alu_b/alu_op.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  RES_W  captured result.
- res_op  out  OP_W  opcode that produced res_data.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All state clears immediately on rst=1.
- Reset values: alu_a=0, alu_b=0, alu_op=0, res_valid=0, res_data=0, res_op=0, count=0. FIFO pointers are 0 and FSM is in IDLE. in_ready=1 after reset.
- Push: on an edge with in_valid & in_ready, write {in_a, in_b, in_op} at wr_ptr; wr_ptr+1 (wraps mod DEPTH); count+1.
- in_ready = (count != DEPTH). A push is refused when full even if a pop happens in the same cycle.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if count != 0, pop at the edge. Load alu_a/alu_b/alu_op from the head entry; rd_ptr+1 (wrap); go to EXEC. Otherwise stay in IDLE and alu_* hold their values.
  - EXEC: at the edge, res_data <= alu_out, res_op <= alu_op, res_valid <= 1; go to HOLD.
  - HOLD: res_valid=1 and res_data/res_op stable. On an edge with res_ready=1, res_valid <= 0 and go to IDLE.
- Simultaneous push and pop (IDLE, not full): both occur; count is unchanged.
- Latency: a triple accepted into an empty FIFO with the FSM in IDLE at edge N is popped at edge N+1, and res_valid rises at edge N+2.
- Throughput: at most one result per 3 cycles with res_ready held high.
- Backpressure: res_ready=0 holds HOLD indefinitely. The FIFO keeps filling until in_ready=0. No data is lost or reordered.
- count: pushes minus pops; never exceeds DEPTH or goes below 0.
- Reset mid-operation: an in-flight result and all queued entries are discarded; res_valid drops asynchronously.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds output `done_cnt [7:0]`, reset 0. It increments on every res_valid & res_ready edge and wraps 255→0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `alu_pkg` holds:
  - OP_W and RES_W defaults.
  - Opcode localparams OP_0..OP_6 (3'b000..3'b110, zero-extended to OP_W).
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, HOLD=2'd2.
- Sub-module `alu_issue_fifo`: storage, pointers, count, full/empty. The FSM and capture registers stay in the top-level module.

Test Plan:
- Single op: after reset, push {a=0, b=1, op=3'b010} at edge N with res_ready=1 -> alu_op=3'b010 after N+1; res_valid=1 after N+2 with res_op=3'b010 and res_data equal to the ALU model output.
- Fill: hold res_ready=0 and push 5 triples back-to-back -> 4 accepted plus 1 issued to ALU; in_ready=0 while count=4. Release res_ready -> all 5 results emerge in push order.
- Wrap-around: push and drain 10 triples cycling op 000..110 -> pointers wrap past DEPTH, results stay in order, count returns to 0.
- Simultaneous push/pop: count=2, FSM in IDLE, push on the same edge as a pop -> count stays 2.
- Reset mid-flight: assert rst while in HOLD with count=3 -> res_valid=0, count=0 and alu_op=0 immediately. The next push produces a result 2 edges later.
- With ALU_ISSUE_STATS_EN: complete 257 results -> done_cnt=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue unit.
//   DEF_OP_W / DEF_RES_W : default opcode / result widths (match the alu block)
//   OP_0..OP_6           : opcode encodings, zero-extended to DEF_OP_W
//   issue_state_e        : issue FSM encoding (IDLE, EXEC, HOLD)
package alu_pkg;

    localparam int DEF_OP_W  = 4;
    localparam int DEF_RES_W = 4;

    localparam logic [DEF_OP_W-1:0] OP_0 = DEF_OP_W'(3'b000);
    localparam logic [DEF_OP_W-1:0] OP_1 = DEF_OP_W'(3'b001);
    localparam logic [DEF_OP_W-1:0] OP_2 = DEF_OP_W'(3'b010);
    localparam logic [DEF_OP_W-1:0] OP_3 = DEF_OP_W'(3'b011);
    localparam logic [DEF_OP_W-1:0] OP_4 = DEF_OP_W'(3'b100);
    localparam logic [DEF_OP_W-1:0] OP_5 = DEF_OP_W'(3'b101);
    localparam logic [DEF_OP_W-1:0] OP_6 = DEF_OP_W'(3'b110);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: circular buffer holding {a, b, op} triples for the issue unit.
//   clk, rst   : clock, asynchronous active-high reset
//   push_req   : producer wants to write wdata (ignored while full)
//   wdata      : entry to write
//   pop        : consume the head entry (ignored while empty)
//   rdata      : head entry (valid while !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module alu_issue_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_req,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    push_ok;
    logic                    pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Fullness is judged before any same-edge pop, so a full FIFO refuses
    // a push even while the head is leaving.
    assign push_ok = push_req && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: buffers {a, b, op} triples and issues them one at a time to
// a combinational ALU, then presents each result over a valid/ready handshake.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : producer handshake; in_ready = !full
//   in_a, in_b, in_op        : incoming triple
//   alu_a, alu_b, alu_op     : registered drive to the ALU
//   alu_out                  : ALU result (combinational from alu_*)
//   res_valid/res_ready      : consumer handshake
//   res_data, res_op         : captured result and the opcode that produced it
//   count                    : FIFO occupancy
//   done_cnt                 : completed results mod 256 (only with ALU_ISSUE_STATS_EN)
// Optional feature macro: ALU_ISSUE_STATS_EN.
module alu_issue_unit #(
    parameter int OP_W  = alu_pkg::DEF_OP_W,
    parameter int RES_W = alu_pkg::DEF_RES_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_a,
    input  logic                       in_b,
    input  logic [OP_W-1:0]            in_op,
    output logic                       alu_a,
    output logic                       alu_b,
    output logic [OP_W-1:0]            alu_op,
    input  logic [RES_W-1:0]           alu_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RES_W-1:0]           res_data,
    output logic [OP_W-1:0]            res_op,
`ifdef ALU_ISSUE_STATS_EN
    output logic [7:0]                 done_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import alu_pkg::*;

    localparam int EW = OP_W + 2;

    issue_state_e   state;
    logic [EW-1:0]  head;
    logic           full;
    logic           empty;
    logic           pop;

    // The head is taken only when the ALU slot is free.
    assign pop      = (state == IDLE) && !empty;
    assign in_ready = !full;

    alu_issue_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (in_valid),
        .wdata    ({in_a, in_b, in_op}),
        .pop      (pop),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // IDLE loads the ALU operands, EXEC gives the ALU one cycle to settle and
    // captures its output, HOLD presents the result until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= 1'b0;
            alu_b     <= 1'b0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {alu_a, alu_b, alu_op} <= head;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_out;
                    res_op    <= alu_op;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           done_cnt <= 8'd0;
        else if (res_valid && res_ready)   done_cnt <= done_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: randomized and directed bench for alu_issue_unit with a
// queue-based reference model and an in-order result scoreboard.
module tb_alu_issue_unit;

    localparam int OP_W  = 4;
    localparam int RES_W = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic            a;
        logic            b;
        logic [OP_W-1:0] op;
    } trip_t;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [OP_W-1:0]  op;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_a = 1'b0;
    logic             in_b = 1'b0;
    logic [OP_W-1:0]  in_op = '0;
    logic             alu_a;
    logic             alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [RES_W-1:0] alu_out;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [RES_W-1:0] res_data;
    logic [OP_W-1:0]  res_op;
    logic [2:0]       count;
`ifdef ALU_ISSUE_STATS_EN
    logic [7:0]       done_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // Stand-in for the combinational alu block.
    function automatic logic [RES_W-1:0] alu_fn(input logic a, input logic b,
                                                input logic [OP_W-1:0] op);
        case (op)
            4'd0:    return {3'b000, a & b};
            4'd1:    return {3'b000, a | b};
            4'd2:    return {3'b000, a ^ b};
            4'd3:    return {3'b000, a} + {3'b000, b};
            4'd4:    return {3'b000, a} - {3'b000, b};
            4'd5:    return {a, b, a, b};
            4'd6:    return {b, a, 2'b01};
            default: return 4'hA;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    alu_issue_unit #(
        .OP_W  (OP_W),
        .RES_W (RES_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
`ifdef ALU_ISSUE_STATS_EN
        .done_cnt  (done_cnt),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    trip_t      m_q[$];     // queued triples
    res_t       sb[$];      // expected results in push order
    int         m_stage;    // 0 free, 1 operands on ALU, 2 result presented
    logic       m_a, m_b;
    logic [3:0] m_op;
    logic [3:0] m_rd, m_ro;
    logic       m_rv;
    logic [7:0] m_done;

    task model_step();
        trip_t t;
        logic  do_push;
        if (rst) begin
            m_q.delete();
            sb.delete();
            m_stage = 0;
            m_a = 0; m_b = 0; m_op = 0;
            m_rd = 0; m_ro = 0; m_rv = 0; m_done = 0;
            return;
        end
        do_push = in_valid && (m_q.size() != DEPTH);
        if (m_stage == 0) begin
            if (m_q.size() != 0) begin
                t = m_q.pop_front();
                m_a = t.a; m_b = t.b; m_op = t.op;
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            m_rd = alu_fn(m_a, m_b, m_op);
            m_ro = m_op;
            m_rv = 1'b1;
            m_stage = 2;
        end else if (res_ready) begin
            m_rv = 1'b0;
            m_done = m_done + 8'd1;
            m_stage = 0;
        end
        if (do_push) begin
            t.a = in_a; t.b = in_b; t.op = in_op;
            m_q.push_back(t);
            sb.push_back({alu_fn(in_a, in_b, in_op), in_op});
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        res_t e;
        chk("in_ready",  32'(in_ready),  32'(m_q.size() != DEPTH));
        chk("count",     32'(count),     32'(m_q.size()));
        chk("alu_a",     32'(alu_a),     32'(m_a));
        chk("alu_b",     32'(alu_b),     32'(m_b));
        chk("alu_op",    32'(alu_op),    32'(m_op));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_data",  32'(res_data),  32'(m_rd));
        chk("res_op",    32'(res_op),    32'(m_ro));
`ifdef ALU_ISSUE_STATS_EN
        chk("done_cnt",  32'(done_cnt),  32'(m_done));
`endif
        // res_ready only changes just after posedge, so this is the handshake edge.
        if (!rst && m_rv && res_ready) begin
            chk("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("order_data", 32'(res_data), 32'(e.res));
                chk("order_op",   32'(res_op),   32'(e.op));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic a, input logic b, input logic [3:0] op);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int k = 0; k < 100; k++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (m_q.size() == 0 && m_stage == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_alu_op",    32'(alu_op),    32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_res_data",  32'(res_data),  32'd0);
        rst = 1'b0;
        tick();

        // Single op: a=0 b=1 op=2 -> xor = 1
        res_ready = 1'b1;
        push_one(1'b0, 1'b1, 4'd2);             // edge N
        chk("single_count_n", 32'(count), 32'd1);
        tick();                                  // edge N+1
        chk("single_alu_op", 32'(alu_op), 32'd2);
        chk("single_not_yet", 32'(res_valid), 32'd0);
        tick();                                  // edge N+2
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data",  32'(res_data),  32'd1);
        chk("single_op",    32'(res_op),    32'd2);
        tick();                                  // handshake
        chk("single_taken", 32'(res_valid), 32'd0);

        // Fill with backpressure
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_one(1'($urandom), 1'($urandom), 4'($urandom_range(0, 6)));
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_op = 4'd3;
        tick();                                  // refused push
        in_valid = 1'b0;
        chk("fill_refused", 32'(count), 32'd4);
        drain();
        chk("fill_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap-around: 10 triples cycling op 0..6
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            push_one(1'(i), 1'(i >> 1), 4'(i % 7));
        drain();
        chk("wrap_count", 32'(count), 32'd0);

        // Simultaneous push/pop with count=2 in IDLE
        res_ready = 1'b0;
        push_one(1'b1, 1'b1, 4'd0);
        push_one(1'b1, 1'b0, 4'd1);
        push_one(1'b0, 1'b1, 4'd3);
        chk("sim_pre_count", 32'(count), 32'd2);
        chk("sim_hold", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("sim_idle_count", 32'(count), 32'd2);
        push_one(1'b1, 1'b1, 4'd5);              // pop and push on one edge
        chk("sim_count", 32'(count), 32'd2);
        chk("sim_alu_op", 32'(alu_op), 32'd1);
        push_one(1'b0, 1'b0, 4'd6);
        chk("mid_count3", 32'(count), 32'd3);
        chk("mid_hold", 32'(res_valid), 32'd1);

        // Reset mid-flight
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        push_one(1'b1, 1'b1, 4'd3);              // edge N
        tick();                                  // N+1
        chk("post_rst_n1", 32'(res_valid), 32'd0);
        tick();                                  // N+2
        chk("post_rst_valid", 32'(res_valid), 32'd1);
        chk("post_rst_data", 32'(res_data), 32'd2);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_a      = 1'($urandom);
            in_b      = 1'($urandom);
            in_op     = 4'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 257; i++)
            push_one(1'($urandom), 1'($urandom), 4'($urandom_range(0, 6)));
        drain();
        chk("done_cnt_257", 32'(done_cnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
